// File: rtl/cbus_arbiter.sv
// cbus_arbiter: grants one cache requester the shared cbus memory port per burst.
// Define CBUS_ARB_RR_EN for round-robin arbitration; fixed priority (index 0 highest) otherwise.
module cbus_arbiter #(
  parameter int N_REQ    = 2,
  parameter int SEL_BITS = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N_REQ-1:0]    ireq_valid,
  input  logic [N_REQ-1:0]    ireq_is_write,
  input  logic [N_REQ*3-1:0]  ireq_size,
  input  logic [N_REQ*64-1:0] ireq_addr,
  input  logic [N_REQ*8-1:0]  ireq_strobe,
  input  logic [N_REQ*64-1:0] ireq_data,
  input  logic [N_REQ*4-1:0]  ireq_len,
  input  logic [N_REQ*2-1:0]  ireq_burst,
  output logic [N_REQ-1:0]    iresp_ready,
  output logic [N_REQ-1:0]    iresp_last,
  output logic [N_REQ*64-1:0] iresp_data,
  output logic                oreq_valid,
  output logic                oreq_is_write,
  output logic [2:0]          oreq_size,
  output logic [63:0]         oreq_addr,
  output logic [7:0]          oreq_strobe,
  output logic [63:0]         oreq_data,
  output logic [3:0]          oreq_len,
  output logic [1:0]          oreq_burst,
  input  logic                oresp_ready,
  input  logic                oresp_last,
  input  logic [63:0]         oresp_data,
  output logic [N_REQ-1:0]    gnt
);
  typedef enum logic {IDLE, BUSY} state_e;
  state_e state_q, state_d;
  logic [SEL_BITS-1:0] sel_q, sel_d, win;
  logic busy;
  assign busy = state_q == BUSY;
`ifdef CBUS_ARB_RR_EN
  logic [SEL_BITS-1:0] last_gnt_q;
  logic found;
  always_comb begin
    win   = '0;
    found = 1'b0;
    for (int i = 0; i < N_REQ; i++)
      if (!found && ireq_valid[(int'(last_gnt_q) + 1 + i) % N_REQ]) begin
        win   = SEL_BITS'((int'(last_gnt_q) + 1 + i) % N_REQ);
        found = 1'b1;
      end
  end
  always_ff @(posedge clk)
    if (!reset) last_gnt_q <= '0;
    else if (!busy && |ireq_valid) last_gnt_q <= win;
`else
  always_comb begin
    win = '0;
    for (int i = N_REQ - 1; i >= 0; i--)
      if (ireq_valid[i]) win = SEL_BITS'(i);
  end
`endif
  always_ff @(posedge clk)
    if (!reset) begin
      state_q <= IDLE;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
    end
  // A dropped valid from the owner ends the burst just like a final beat
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    if (!busy) begin
      if (|ireq_valid) begin
        state_d = BUSY;
        sel_d   = win;
      end
    end else if ((oresp_ready && oresp_last) || !ireq_valid[sel_q]) state_d = IDLE;
  end
  assign oreq_valid    = busy & ireq_valid[sel_q];
  assign oreq_is_write = busy & ireq_is_write[sel_q];
  assign oreq_size     = busy ? ireq_size[int'(sel_q)*3 +: 3] : '0;
  assign oreq_addr     = busy ? ireq_addr[int'(sel_q)*64 +: 64] : '0;
  assign oreq_strobe   = busy ? ireq_strobe[int'(sel_q)*8 +: 8] : '0;
  assign oreq_data     = busy ? ireq_data[int'(sel_q)*64 +: 64] : '0;
  assign oreq_len      = busy ? ireq_len[int'(sel_q)*4 +: 4] : '0;
  assign oreq_burst    = busy ? ireq_burst[int'(sel_q)*2 +: 2] : '0;
  assign gnt           = busy ? N_REQ'(1) << sel_q : '0;
  always_comb begin
    iresp_ready = '0;
    iresp_last  = '0;
    iresp_data  = '0;
    if (busy) begin
      iresp_ready[sel_q]               = oresp_ready;
      iresp_last[sel_q]                = oresp_last;
      iresp_data[int'(sel_q)*64 +: 64] = oresp_data;
    end
  end
endmodule

// File: tb/tb_cbus_arbiter.sv
// tb_cbus_arbiter: directed checks of grant, pass-through, abort and reset behaviour.
module tb_cbus_arbiter;
  localparam int N = 2;
`ifdef CBUS_ARB_RR_EN
  localparam int W0 = 1;
`else
  localparam int W0 = 0;
`endif
  logic clk = 0, reset = 0;
  logic [N-1:0] ireq_valid = '0, ireq_is_write = '0;
  logic [N*3-1:0] ireq_size = '0;
  logic [N*64-1:0] ireq_addr = '0, ireq_data = '0;
  logic [N*8-1:0] ireq_strobe = '0;
  logic [N*4-1:0] ireq_len = '0;
  logic [N*2-1:0] ireq_burst = '0;
  logic [N-1:0] iresp_ready, iresp_last, gnt;
  logic [N*64-1:0] iresp_data;
  logic oreq_valid, oreq_is_write;
  logic [2:0] oreq_size;
  logic [63:0] oreq_addr, oreq_data;
  logic [7:0] oreq_strobe;
  logic [3:0] oreq_len;
  logic [1:0] oreq_burst;
  logic oresp_ready = 0, oresp_last = 0;
  logic [63:0] oresp_data = '0;
  int checks = 0, failures = 0;

  cbus_arbiter #(.N_REQ(N)) dut (
    .clk(clk), .reset(reset),
    .ireq_valid(ireq_valid), .ireq_is_write(ireq_is_write), .ireq_size(ireq_size),
    .ireq_addr(ireq_addr), .ireq_strobe(ireq_strobe), .ireq_data(ireq_data),
    .ireq_len(ireq_len), .ireq_burst(ireq_burst),
    .iresp_ready(iresp_ready), .iresp_last(iresp_last), .iresp_data(iresp_data),
    .oreq_valid(oreq_valid), .oreq_is_write(oreq_is_write), .oreq_size(oreq_size),
    .oreq_addr(oreq_addr), .oreq_strobe(oreq_strobe), .oreq_data(oreq_data),
    .oreq_len(oreq_len), .oreq_burst(oreq_burst),
    .oresp_ready(oresp_ready), .oresp_last(oresp_last), .oresp_data(oresp_data),
    .gnt(gnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic beat(input logic rdy, input logic lst, input logic [63:0] d);
    oresp_ready = rdy;
    oresp_last  = lst;
    oresp_data  = d;
    #1;
  endtask

  initial begin
    tick; tick;
    chk("rst_gnt", 64'(gnt), 0);
    chk("rst_oreq_valid", 64'(oreq_valid), 0);
    chk("rst_iresp_ready", 64'(iresp_ready), 0);
    reset = 1;
    // single 16-beat read from requester 0
    ireq_valid = 2'b01;
    ireq_addr[63:0] = 64'h8000_0080;
    ireq_len[3:0] = 4'hF;
    #1 chk("idle_oreq_valid", 64'(oreq_valid), 0);
    tick;
    chk("rd_oreq_valid", 64'(oreq_valid), 1);
    chk("rd_oreq_addr", oreq_addr, 64'h8000_0080);
    chk("rd_oreq_len", 64'(oreq_len), 64'hF);
    chk("rd_gnt", 64'(gnt), 64'b01);
    for (int b = 0; b < 16; b++) begin
      beat(1'b1, b == 15, 64'(16 + b));
      chk("rd_data0", iresp_data[63:0], 64'(16 + b));
      chk("rd_ready", 64'(iresp_ready), 64'b01);
      chk("rd_last", 64'(iresp_last), b == 15 ? 64'b01 : 64'b00);
      chk("rd_data1", iresp_data[127:64], 0);
      tick;
    end
    ireq_valid = 2'b00;
    beat(1'b0, 1'b0, 64'h0);
    chk("rd_idle_gnt", 64'(gnt), 0);
    chk("rd_idle_valid", 64'(oreq_valid), 0);
    // contention: both valid in the same cycle
    ireq_valid = 2'b11;
    ireq_addr[127:64] = 64'h9000_0100;
    tick;
    chk("ct_gnt_first", 64'(gnt), 64'(2'b01 << W0));
    chk("ct_addr_first", oreq_addr, W0 == 0 ? 64'h8000_0080 : 64'h9000_0100);
    beat(1'b1, 1'b0, 64'h55);
    chk("ct_gnt_beat1", 64'(gnt), 64'(2'b01 << W0));
    tick;
    beat(1'b1, 1'b1, 64'h66);
    chk("ct_last", 64'(iresp_last), 64'(2'b01 << W0));
    tick;
    ireq_valid[W0] = 1'b0;
    beat(1'b0, 1'b0, 64'h0);
    chk("ct_gap_gnt", 64'(gnt), 0);
    tick;
    chk("ct_gnt_second", 64'(gnt), 64'(2'b01 << (1 - W0)));
    chk("ct_addr_second", oreq_addr, W0 == 0 ? 64'h9000_0100 : 64'h8000_0080);
    beat(1'b1, 1'b1, 64'h77);
    chk("ct_second_ready", 64'(iresp_ready), 64'(2'b01 << (1 - W0)));
    tick;
    ireq_valid = 2'b00;
    beat(1'b0, 1'b0, 64'h0);
    // write pass-through from requester 1
    ireq_valid = 2'b10;
    ireq_is_write = 2'b10;
    ireq_strobe[15:8] = 8'hFF;
    tick;
    chk("wr_gnt", 64'(gnt), 64'b10);
    for (int b = 0; b < 3; b++) begin
      ireq_data[127:64] = 64'hA0 + 64'(b);
      beat(1'b1, b == 2, 64'h0);
      chk("wr_data", oreq_data, 64'hA0 + 64'(b));
      chk("wr_is_write", 64'(oreq_is_write), 1);
      tick;
    end
    chk("wr_strobe_idle", 64'(oreq_strobe), 0);
    ireq_valid = 2'b00;
    ireq_is_write = 2'b00;
    beat(1'b0, 1'b0, 64'h0);
    // abort: requester 0 drops valid after beat 3
    ireq_valid = 2'b11;
    tick;
    chk("ab_gnt", 64'(gnt), 64'b01);
    for (int b = 0; b < 3; b++) begin
      beat(1'b1, 1'b0, 64'(b));
      tick;
    end
    ireq_valid[0] = 1'b0;
    beat(1'b0, 1'b0, 64'h0);
    chk("ab_oreq_valid", 64'(oreq_valid), 0);
    tick;
    chk("ab_idle_gnt", 64'(gnt), 0);
    tick;
    chk("ab_other_gnt", 64'(gnt), 64'b10);
    beat(1'b1, 1'b1, 64'h1);
    tick;
    ireq_valid = 2'b00;
    beat(1'b0, 1'b0, 64'h0);
    // reset in the middle of a burst
    ireq_valid = 2'b01;
    tick;
    chk("rs_gnt", 64'(gnt), 64'b01);
    for (int b = 0; b < 4; b++) begin
      beat(1'b1, 1'b0, 64'(b));
      tick;
    end
    reset = 0;
    tick;
    #1;
    chk("rs_gnt_zero", 64'(gnt), 0);
    chk("rs_oreq_valid", 64'(oreq_valid), 0);
    chk("rs_iresp_ready", 64'(iresp_ready), 0);
    chk("rs_iresp_data", iresp_data[63:0], 0);
    reset = 1;
    beat(1'b0, 1'b0, 64'h0);
    tick;
    chk("rs_regrant", 64'(gnt), 64'b01);
    chk("rs_regrant_valid", 64'(oreq_valid), 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cbus_arbiter.md
Name: cbus_arbiter

Overview:
- Shares the single cache-bus (cbus) memory port between N cache-side requesters, typically DCache and ICache.
- Sits between the L1 caches and the memory/AXI bridge.
- Grants one requester for a whole burst and holds the grant until the last beat completes.
- Forwards the winner's request to memory and steers the response back to the winner only.

Parameters:
- N_REQ, 2, number of requesters; index 0 is highest fixed priority (DCache).
- SEL_BITS, $clog2(N_REQ) (min 1), width of the internal grant index.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-low.
- ireq_valid  in  N_REQ  per-requester request valid.
- ireq_is_write  in  N_REQ  per-requester write flag.
- ireq_size  in  N_REQ*3  per-requester access size (MSIZE encoding).
- ireq_addr  in  N_REQ*64  per-requester start address.
- ireq_strobe  in  N_REQ*8  per-requester write byte strobe.
- ireq_data  in  N_REQ*64  per-requester write data.
- ireq_len  in  N_REQ*4  per-requester burst length (MLEN encoding).
- ireq_burst  in  N_REQ*2  per-requester burst type.
- iresp_ready  out  N_REQ  per-requester beat accepted/valid.
- iresp_last  out  N_REQ  per-requester final beat.
- iresp_data  out  N_REQ*64  per-requester read data.
- oreq_valid, oreq_is_write, oreq_size, oreq_addr, oreq_strobe, oreq_data, oreq_len, oreq_burst  out  1/1/3/64/8/64/4/2  request to memory.
- oresp_ready, oresp_last  in  1/1  memory beat handshake.
- oresp_data  in  64  memory read data.
- gnt  out  N_REQ  one-hot current grant, 0 when idle (debug/perf).

Behaviour:
- FSM states: IDLE and BUSY. Registered grant index sel.
- Reset (reset==0 at clk edge):
  - state=IDLE, sel=0, gnt=0.
  - All oreq_* = 0; all iresp_* = 0.
  - Reset mid-burst abandons the transaction immediately.
- IDLE:
  - oreq_* driven 0; iresp_* driven 0.
  - If any ireq_valid, pick a winner per the arbitration policy, latch it in sel, go to BUSY next cycle.
  - Latency: valid at cycle t gives oreq_valid=1 at t+1.
- BUSY:
  - oreq_* = ireq_*[sel], combinational pass-through, so beat-wise changes in data/strobe reach memory.
  - oreq_valid = ireq_valid[sel].
  - iresp_ready[sel]=oresp_ready, iresp_last[sel]=oresp_last, iresp_data[sel]=oresp_data.
  - Non-granted requesters see ready=0, last=0, data=0.
  - gnt = one-hot(sel).
- BUSY -> IDLE when either:
  - oresp_ready && oresp_last, or
  - ireq_valid[sel]==0 (requester abort).
- At least one IDLE cycle always follows each transaction. No back-to-back grant in the same cycle.
- Requests arriving during BUSY are held by their requesters (valid stays high); they are not lost.
- Simultaneous requests in IDLE are resolved by policy. Ties never yield a multi-hot gnt.
- No ordering or addr_ok semantics are added. The requesters own their retry.

Optional Feature:
- Macro CBUS_ARB_RR_EN.
- Defined: round-robin arbitration.
  - A pointer register last_gnt (reset 0) is updated on every grant.
  - Search starts at (last_gnt+1) mod N_REQ; the first valid requester wins.
- Undefined: fixed priority; the lowest index with valid set wins. last_gnt is absent.

Test Plan:
- Single read: ireq_valid=01, addr=0x8000_0080, len=MLEN16.
  - oreq_valid at t+1 with addr 0x8000_0080.
  - 16 beats data 0x10..0x1F to iresp_data[0].
  - iresp_last[0] on beat 16; IDLE the next cycle; iresp[1] stays 0 throughout.
- Contention, fixed priority: both valid at t.
  - gnt=01 for the full burst, then gnt=00 for 1 cycle, then gnt=10.
  - With CBUS_ARB_RR_EN and last_gnt=0, gnt=10 first.
- Round-robin fairness (CBUS_ARB_RR_EN): both requesters continuously valid, 1-beat bursts.
  - gnt alternates 01,10,01,10 with one idle cycle between.
- Write pass-through: requester 1 is_write=1, strobe=0xFF, data changes each beat.
  - oreq_data tracks ireq_data[1] the same cycle; oreq_is_write=1.
- Abort: the granted requester drops valid after beat 3 of 16.
  - IDLE the next cycle; oreq_valid=0; the other pending requester is granted after that.
- Reset mid-burst: reset=0 for one cycle at beat 5.
  - Next cycle all outputs 0, gnt=0.
  - A request after reset release is granted normally.
